// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 key-event receiver: scan codes, direction encoding,
// event layout and frame FSM state codes.
package ps2_pkg;

    localparam logic [7:0] SC_E0   = 8'hE0;
    localparam logic [7:0] SC_E1   = 8'hE1;
    localparam logic [7:0] SC_F0   = 8'hF0;
    localparam logic [7:0] SC_OVR0 = 8'h00;
    localparam logic [7:0] SC_OVRF = 8'hFF;
    localparam logic [7:0] SC_W    = 8'h1D;
    localparam logic [7:0] SC_I    = 8'h43;
    localparam logic [7:0] SC_A    = 8'h1C;
    localparam logic [7:0] SC_J    = 8'h3B;
    localparam logic [7:0] SC_D    = 8'h23;
    localparam logic [7:0] SC_L    = 8'h4B;

    localparam logic [1:0] DIR_NONE     = 2'd0;
    localparam logic [1:0] DIR_STRAIGHT = 2'd1;
    localparam logic [1:0] DIR_LEFT     = 2'd2;
    localparam logic [1:0] DIR_RIGHT    = 2'd3;

    // Held-key map bit positions
    localparam int HK_W = 0;
    localparam int HK_I = 1;
    localparam int HK_A = 2;
    localparam int HK_J = 3;
    localparam int HK_D = 4;
    localparam int HK_L = 5;

    localparam int EV_W        = 10;
    localparam int EV_CODE_LSB = 0;
    localparam int EV_BRK_BIT  = 8;
    localparam int EV_EXT_BIT  = 9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    function automatic logic [1:0] dir_of(input logic [5:0] held);
        if (held[HK_W] || held[HK_I])
            return DIR_STRAIGHT;
        else if (held[HK_A] || held[HK_J])
            return DIR_LEFT;
        else if (held[HK_D] || held[HK_L])
            return DIR_RIGHT;
        else
            return DIR_NONE;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through FIFO for key events; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module ps2_event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_en;
    logic             wr_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_en = pop && !empty;
    assign wr_en  = push && (!full || pop_en);
    assign dout   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_key_event_rx.sv
// Framed PS/2 keyboard receiver: glitch-filtered clock, 11-bit frame check with watchdog,
// E0/F0 prefix decoding into a buffered event stream, and held-key direction tracking.
module ps2_key_event_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [1:0] dir,
    output logic       frame_err,
    output logic       overflow,
    input  logic       ovf_clr
);

    import ps2_pkg::*;

    localparam int FC_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_filt;
    logic [FC_W-1:0]        filt_cnt;
    logic                   fall;

    logic [1:0]      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par;
    logic            byte_vld;
    logic            byte_err;
    logic [WD_W-1:0] wd;
    logic            wd_expire;

    logic            ext_pend;
    logic            brk_pend;
    logic            is_ovr;
    logic            is_skip;
    logic            push;
    logic            pop;
    logic            drop;
    logic            full;
    logic            empty;
    logic [5:0]      held;
    logic [5:0]      held_nxt;
    logic [EV_W-1:0] head;

    // Idle PS/2 lines are high, so the synchronisers and filter come out of reset at 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s != clk_filt) begin
                if (filt_cnt == FC_LAST) begin
                    clk_filt <= clk_s;
                    filt_cnt <= '0;
                    fall     <= !clk_s;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // wd holds the number of cycles since the most recent fall while a frame is open
    assign wd_expire = !fall && (state != ST_IDLE) && (wd == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            byte_vld <= 1'b0;
            byte_err <= 1'b0;
            wd       <= '0;
        end else begin
            byte_vld <= 1'b0;
            byte_err <= 1'b0;
            if (fall) begin
                wd <= WD_W'(1);
                case (state)
                    ST_IDLE: begin
                        if (!data_s) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par   <= data_s;
                        state <= ST_STOP;
                    end
                    default: begin
                        if ((^{shreg, par}) && data_s)
                            byte_vld <= 1'b1;
                        else
                            byte_err <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end else if (wd_expire) begin
                state <= ST_IDLE;
                wd    <= '0;
            end else if (state != ST_IDLE) begin
                wd <= wd + 1'b1;
            end else begin
                wd <= '0;
            end
        end
    end

    assign is_ovr  = (shreg == SC_OVR0) || (shreg == SC_OVRF);
    assign is_skip = (shreg == SC_E0) || (shreg == SC_F0) || (shreg == SC_E1);
    assign push    = byte_vld && !is_ovr && !is_skip;

    // Handshake: the head entry transfers on any cycle where ev_valid and ev_ready are both
    // high; ev_valid never depends on ev_ready and the head fields hold until popped.
    assign ev_valid = !empty;
    assign pop      = ev_ready && !empty;
    assign drop     = push && full && !pop;

    always_comb begin
        held_nxt = held;
        if (push && !ext_pend) begin
            case (shreg)
                SC_W:    held_nxt[HK_W] = !brk_pend;
                SC_I:    held_nxt[HK_I] = !brk_pend;
                SC_A:    held_nxt[HK_A] = !brk_pend;
                SC_J:    held_nxt[HK_J] = !brk_pend;
                SC_D:    held_nxt[HK_D] = !brk_pend;
                SC_L:    held_nxt[HK_L] = !brk_pend;
                default: held_nxt = held;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            held      <= '0;
            dir       <= DIR_NONE;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= byte_err || wd_expire || (byte_vld && is_ovr);
            held      <= held_nxt;
            dir       <= dir_of(held_nxt);
            if (byte_vld) begin
                if (shreg == SC_E0)
                    ext_pend <= 1'b1;
                else if (shreg == SC_F0)
                    brk_pend <= 1'b1;
                else if (shreg != SC_E1) begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
            // A drop in the same cycle as ovf_clr keeps the flag set
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    ps2_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({ext_pend, brk_pend, shreg}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign ev_code  = head[EV_CODE_LSB +: 8];
    assign ev_break = head[EV_BRK_BIT];
    assign ev_ext   = head[EV_EXT_BIT];

endmodule
